tlb_maint_ctrl: RTL and testbench

Sequences INVTLB as a multi-cycle sweep over the 16-entry TLB and arbitrates the shared TLB search port s1. Requesters on s1 are data-address translation and the EXE-stage TLBSRCH. It sits between the pipeline stages and the TLB, beside the WB-stage CSR/TLB logic. WB-stage TLBRD/TLBWR/TLBFILL accesses always take precedence on the read and write ports.

---
 rtl/tlb_maint_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_tlb_maint_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_maint_ctrl.sv
// INVTLB sweep sequencer and s1 search-port arbiter for a TLBNUM-entry TLB.
// WB-stage TLB accesses always override the sweep on the read/write ports.
module tlb_maint_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dt_req,
    input  logic [18:0]   dt_vppn,
    input  logic          dt_va12,
    input  logic [9:0]    dt_asid,
    output logic          dt_gnt,
    input  logic          srch_req,
    input  logic [18:0]   srch_vppn,
    input  logic          srch_va12,
    input  logic [9:0]    srch_asid,
    output logic          srch_gnt,
    output logic [18:0]   s1_vppn,
    output logic          s1_va_bit12,
    output logic [9:0]    s1_asid,
    input  logic          inv_valid,
    input  logic [4:0]    inv_op,
    input  logic [9:0]    inv_asid,
    input  logic [18:0]   inv_vppn,
    output logic          inv_ready,
    output logic          inv_done,
    output logic          inv_err,
    output logic          busy,
    input  logic          wb_tlb_we,
    input  logic [IW-1:0] wb_w_index,
    input  logic [IW-1:0] wb_r_index,
    input  logic          wb_w_e,
    input  logic          wb_tlb_act,
    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic          r_g,
    input  logic [5:0]    r_ps,
    input  logic [9:0]    r_asid,
    input  logic [18:0]   r_vppn,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic          w_e
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(TLBNUM - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          last_gnt_q, last_gnt_d;
    logic          err_q, err_d;
    logic [2:0]    op_q;
    logic [9:0]    asid_q;
    logic [18:0]   vppn_q;
    logic          accept;
    logic          sweep_go;
    logic          hit;

    // A 2 MB page (ps==21) only compares the VPPN bits above the page offset.
    function automatic logic va_match(input logic [5:0] ps, input logic [18:0] ev,
                                      input logic [18:0] cv);
        logic m;
        if (ps == 6'd21) m = (ev[18:9] == cv[18:9]);
        else             m = (ev == cv);
        return m;
    endfunction

    function automatic logic inv_match(input logic [2:0] op, input logic g,
                                       input logic asid_eq, input logic va);
        logic m;
        case (op)
            3'd0, 3'd1: m = 1'b1;
            3'd2:       m = g;
            3'd3:       m = !g;
            3'd4:       m = !g && asid_eq;
            3'd5:       m = !g && asid_eq && va;
            3'd6:       m = (g || asid_eq) && va;
            default:    m = 1'b0;
        endcase
        return m;
    endfunction

    assign accept   = (state_q == IDLE) && inv_valid;
    assign sweep_go = (state_q == SWEEP) && !wb_tlb_act;
    assign hit      = r_e && inv_match(op_q, r_g, r_asid == asid_q,
                                       va_match(r_ps, r_vppn, vppn_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            last_gnt_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
        end
    end

    // Command fields are only consumed during SWEEP, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= inv_op[2:0];
            asid_q <= inv_asid;
            vppn_q <= inv_vppn;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        inv_ready = 1'b0;
        inv_done  = 1'b0;
        inv_err   = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                inv_ready = 1'b1;
                if (inv_valid) begin
                    if (inv_op <= 5'd6) begin
                        idx_d   = '0;
                        state_d = SWEEP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SWEEP: begin
                busy = 1'b1;
                if (!wb_tlb_act) begin
                    idx_d = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy     = 1'b1;
                inv_done = 1'b1;
                inv_err  = err_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // TLB port mux kept apart from the FSM so the read-data path stays acyclic.
    always_comb begin
        r_index = sweep_go ? idx_q : wb_r_index;
    end

    always_comb begin
        we      = wb_tlb_we;
        w_index = wb_w_index;
        w_e     = wb_w_e;
        if (sweep_go) begin
            we      = hit;
            w_index = idx_q;
            w_e     = 1'b0;
        end
    end

    always_comb begin
        dt_gnt      = 1'b0;
        srch_gnt    = 1'b0;
        last_gnt_d  = last_gnt_q;
        s1_vppn     = '0;
        s1_va_bit12 = 1'b0;
        s1_asid     = '0;
        if (state_q == IDLE) begin
            if (dt_req && srch_req) begin
                dt_gnt   = last_gnt_q;
                srch_gnt = !last_gnt_q;
            end else begin
                dt_gnt   = dt_req;
                srch_gnt = srch_req;
            end
        end
        if (dt_gnt) begin
            last_gnt_d  = 1'b0;
            s1_vppn     = dt_vppn;
            s1_va_bit12 = dt_va12;
            s1_asid     = dt_asid;
        end else if (srch_gnt) begin
            last_gnt_d  = 1'b1;
            s1_vppn     = srch_vppn;
            s1_va_bit12 = srch_va12;
            s1_asid     = srch_asid;
        end
    end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Scoreboard bench for tlb_maint_ctrl: a behavioural TLB array, random search
// traffic and INVTLB commands checked against a spec-level reference model.
module tb_tlb_maint_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dt_req = 0, srch_req = 0, dt_va12 = 0, srch_va12 = 0;
    logic [18:0] dt_vppn = 0, srch_vppn = 0;
    logic [9:0]  dt_asid = 0, srch_asid = 0;
    logic        dt_gnt, srch_gnt, s1_va_bit12;
    logic [18:0] s1_vppn;
    logic [9:0]  s1_asid;
    logic        inv_valid = 0;
    logic [4:0]  inv_op = 0;
    logic [9:0]  inv_asid = 0;
    logic [18:0] inv_vppn = 0;
    logic        inv_ready, inv_done, inv_err, busy;
    logic        wb_tlb_we = 0, wb_w_e = 0, wb_tlb_act = 0;
    logic [3:0]  wb_w_index = 0, wb_r_index = 4'hA;
    logic [3:0]  r_index, w_index;
    logic        r_e, r_g, we, w_e;
    logic [5:0]  r_ps;
    logic [9:0]  r_asid;
    logic [18:0] r_vppn;
    logic        wb_g = 0;
    logic [5:0]  wb_ps = 0;
    logic [9:0]  wb_asid = 0;
    logic [18:0] wb_vppn = 0;

    always #5 clk = ~clk;

    tlb_maint_ctrl #(.TLBNUM(16)) dut (
        .clk(clk), .reset(reset),
        .dt_req(dt_req), .dt_vppn(dt_vppn), .dt_va12(dt_va12), .dt_asid(dt_asid),
        .dt_gnt(dt_gnt),
        .srch_req(srch_req), .srch_vppn(srch_vppn), .srch_va12(srch_va12),
        .srch_asid(srch_asid), .srch_gnt(srch_gnt),
        .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .inv_ready(inv_ready), .inv_done(inv_done), .inv_err(inv_err), .busy(busy),
        .wb_tlb_we(wb_tlb_we), .wb_w_index(wb_w_index), .wb_r_index(wb_r_index),
        .wb_w_e(wb_w_e), .wb_tlb_act(wb_tlb_act),
        .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_ps(r_ps), .r_asid(r_asid),
        .r_vppn(r_vppn),
        .we(we), .w_index(w_index), .w_e(w_e)
    );

    // Behavioural TLB storage driven only through the DUT write port.
    bit        tlb_e [16];
    bit        tlb_g [16];
    bit [5:0]  tlb_ps [16];
    bit [9:0]  tlb_asid [16];
    bit [18:0] tlb_vppn [16];

    assign r_e    = tlb_e[r_index];
    assign r_g    = tlb_g[r_index];
    assign r_ps   = tlb_ps[r_index];
    assign r_asid = tlb_asid[r_index];
    assign r_vppn = tlb_vppn[r_index];

    always @(posedge clk) begin
        if (we) begin
            tlb_e[w_index]    <= w_e;
            tlb_g[w_index]    <= wb_g;
            tlb_ps[w_index]   <= wb_ps;
            tlb_asid[w_index] <= wb_asid;
            tlb_vppn[w_index] <= wb_vppn;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_done;
        bit          err;
        logic [15:0] evec;
    } exp_t;
    exp_t q[$];

    int errors = 0;
    int checks = 0;

    function automatic bit spec_match(input int op, input bit g, input bit [9:0] ea,
                                      input bit [5:0] ps, input bit [18:0] ev,
                                      input logic [9:0] ca, input logic [18:0] cv);
        bit va;
        bit ae;
        va = (ps == 6'd21) ? (ev[18:9] == cv[18:9]) : (ev == cv);
        ae = (ea == ca);
        case (op)
            0, 1:    return 1'b1;
            2:       return g;
            3:       return !g;
            4:       return !g && ae;
            5:       return !g && ae && va;
            6:       return (g || ae) && va;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: spec-level expectation of what the DUT must show each cycle.
    int          exp_idx = 16;
    int          acc_cyc = 0;
    int          lat_op = 0;
    logic [9:0]  lat_asid = 0;
    logic [18:0] lat_vppn = 0;
    bit          last = 0;

    always @(negedge clk) begin : mon
        bit          sweep, dn, eb, ed, es, ew;
        logic [15:0] ev;
        logic [29:0] key;
        for (int i = 0; i < 16; i++) ev[i] = tlb_e[i];
        while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("expectation_missed", 32'(cyc), 32'(q[0].cyc));
            void'(q.pop_front());
        end
        if (q.size() > 0 && !q[0].is_done && q[0].cyc == cyc) begin
            chk("probe_busy", busy, 0);
            chk("probe_inv_ready", inv_ready, 1);
            chk("probe_inv_done", inv_done, 0);
            chk("probe_entries", ev, q[0].evec);
            void'(q.pop_front());
        end
        if (reset) begin
            exp_idx = 16;
            last    = 0;
        end else begin
            sweep = (exp_idx < 16) && (cyc > acc_cyc);
            dn    = (q.size() > 0) && q[0].is_done && (q[0].cyc == cyc);
            eb    = sweep || dn;
            chk("busy", busy, eb);
            chk("inv_ready", inv_ready, !eb);

            ed  = !eb && dt_req && (!srch_req || last);
            es  = !eb && srch_req && (!dt_req || !last);
            key = ed ? {dt_vppn, dt_va12, dt_asid} : es ? {srch_vppn, srch_va12, srch_asid} : '0;
            chk("dt_gnt", dt_gnt, ed);
            chk("srch_gnt", srch_gnt, es);
            chk("s1_key", {s1_vppn, s1_va_bit12, s1_asid}, key);
            if (ed) last = 0;
            else if (es) last = 1;

            if (sweep && !wb_tlb_act) begin
                ew = tlb_e[exp_idx] && spec_match(lat_op, tlb_g[exp_idx], tlb_asid[exp_idx],
                                                  tlb_ps[exp_idx], tlb_vppn[exp_idx],
                                                  lat_asid, lat_vppn);
                chk("sweep_r_index", r_index, exp_idx);
                chk("sweep_we", we, ew);
                if (ew) begin
                    chk("sweep_w_index", w_index, exp_idx);
                    chk("sweep_w_e", w_e, 0);
                end
                exp_idx++;
            end else begin
                chk("wb_r_index", r_index, wb_r_index);
                chk("wb_we", we, wb_tlb_we);
                if (wb_tlb_we) chk("wb_w_index", {w_index, w_e}, {wb_w_index, wb_w_e});
            end

            if (inv_done || dn) begin
                chk("inv_done", inv_done, dn);
                if (dn) begin
                    if (inv_done) begin
                        chk("inv_err", inv_err, q[0].err);
                        chk("entries_after_inv", ev, q[0].evec);
                    end
                    void'(q.pop_front());
                end
            end

            if (inv_valid && !eb) begin
                acc_cyc = cyc;
                if (inv_op <= 5'd6) begin
                    exp_idx  = 0;
                    lat_op   = int'(inv_op);
                    lat_asid = inv_asid;
                    lat_vppn = inv_vppn;
                end
            end
        end
    end

    // Random search traffic; the first four cycles hold both requests.
    initial begin
        wait (reset == 1'b0);
        for (int n = 0; ; n++) begin
            @(posedge clk);
            #1;
            dt_req    = (n < 4) ? 1'b1 : 1'($urandom);
            srch_req  = (n < 4) ? 1'b1 : 1'($urandom);
            dt_vppn   = 19'($urandom);
            dt_va12   = 1'($urandom);
            dt_asid   = 10'($urandom);
            srch_vppn = 19'($urandom);
            srch_va12 = 1'($urandom);
            srch_asid = 10'($urandom);
        end
    end

    // Reference copy of the TLB contents, updated only from spec rules.
    bit        md_e [16];
    bit        md_g [16];
    bit [5:0]  md_ps [16];
    bit [9:0]  md_asid [16];
    bit [18:0] md_vppn [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 16; i++) begin
            md_e[i]    = 1'b1;
            md_g[i]    = (mode == 0) ? (i % 2 == 0) : 1'($urandom);
            md_ps[i]   = 6'd12;
            md_asid[i] = 10'($urandom);
            md_vppn[i] = 19'($urandom);
            if (mode == 1 && (i == 3 || i == 9 || i == 10)) begin
                md_g[i]    = 1'b0;
                md_asid[i] = 10'h2A;
                md_vppn[i] = (i == 3) ? 19'h12345 : 19'h12200;
                md_ps[i]   = (i == 10) ? 6'd21 : 6'd12;
            end
            if (mode == 2) begin
                md_e[i]  = 1'($urandom);
                md_ps[i] = $urandom_range(0, 1) ? 6'd21 : 6'd12;
                if ($urandom_range(0, 1)) md_asid[i] = 10'h2A;
                case ($urandom_range(0, 2))
                    0:       md_vppn[i] = 19'h12345;
                    1:       md_vppn[i] = {10'h091, 9'($urandom)};
                    default: md_vppn[i] = 19'($urandom);
                endcase
            end
            step();
            wb_tlb_we  = 1'b1;
            wb_w_index = 4'(i);
            wb_w_e     = md_e[i];
            wb_g       = md_g[i];
            wb_ps      = md_ps[i];
            wb_asid    = md_asid[i];
            wb_vppn    = md_vppn[i];
        end
        step();
        wb_tlb_we = 1'b0;
        wb_w_e    = 1'b0;
    endtask

    function automatic logic [15:0] predict(input int op, input logic [9:0] a,
                                            input logic [18:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++)
            r[i] = md_e[i] && !(op <= 6 && spec_match(op, md_g[i], md_asid[i], md_ps[i],
                                                      md_vppn[i], a, v));
        return r;
    endfunction

    task automatic run_op(input int op, input logic [9:0] a, input logic [18:0] v,
                          input int stall_at, input int stall_len, input bit stall_wr);
        int          t;
        int          done;
        exp_t        it;
        logic [15:0] pv;
        step();
        inv_valid = 1'b1;
        inv_op    = 5'(op);
        inv_asid  = a;
        inv_vppn  = v;
        t         = cyc;
        pv        = predict(op, a, v);
        if (stall_wr) pv[0] = 1'b1;
        done       = (op > 6) ? t + 1 : t + 17 + stall_len;
        it.cyc     = done;
        it.is_done = 1'b1;
        it.err     = (op > 6);
        it.evec    = pv;
        q.push_back(it);
        step();
        if (op <= 6) begin
            inv_op = 5'd7;
            repeat (3) step();
        end
        inv_valid = 1'b0;
        if (stall_len > 0) begin
            while (cyc < t + stall_at) step();
            wb_tlb_act = 1'b1;
            wb_tlb_we  = stall_wr;
            wb_w_index = 4'd0;
            wb_w_e     = 1'b1;
            wb_r_index = 4'h5;
            wb_g       = md_g[0];
            wb_ps      = md_ps[0];
            wb_asid    = md_asid[0];
            wb_vppn    = md_vppn[0];
            repeat (stall_len) step();
            wb_tlb_act = 1'b0;
            wb_tlb_we  = 1'b0;
            wb_w_e     = 1'b0;
            wb_r_index = 4'hA;
        end
        while (cyc < done + 2) step();
        for (int i = 0; i < 16; i++) md_e[i] = pv[i];
    endtask

    task automatic reset_mid_sweep();
        int          t;
        exp_t        it;
        logic [15:0] pv;
        step();
        inv_valid = 1'b1;
        inv_op    = 5'd0;
        t         = cyc;
        step();
        inv_valid = 1'b0;
        for (int i = 0; i < 16; i++) pv[i] = md_e[i] && (i >= 7);
        while (cyc < t + 8) step();
        reset      = 1'b1;
        it.cyc     = t + 8;
        it.is_done = 1'b0;
        it.err     = 1'b0;
        it.evec    = pv;
        q.push_back(it);
        step();
        reset  = 1'b0;
        it.cyc = t + 10;
        q.push_back(it);
        while (cyc < t + 14) step();
        for (int i = 0; i < 16; i++) md_e[i] = pv[i];
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        fill(0);
        run_op(2, 10'($urandom), 19'($urandom), 0, 0, 0);
        fill(1);
        run_op(5, 10'h2A, 19'h12345, 0, 0, 0);
        run_op(7, 10'h2A, 19'h12345, 0, 0, 0);
        fill(0);
        run_op(0, 10'h0, 19'h0, 6, 3, 1);
        fill(2);
        run_op(3, 10'h0, 19'h0, 16, 1, 0);
        fill(2);
        run_op(4, 10'h2A, 19'h12345, 0, 0, 0);
        fill(2);
        run_op(6, 10'h2A, 19'h12345, 0, 0, 0);
        fill(0);
        reset_mid_sweep();
        for (int k = 0; k < 5; k++) begin
            fill(2);
            run_op($urandom_range(0, 7), 10'h2A, 19'h12345,
                   $urandom_range(2, 16), $urandom_range(0, 2), 0);
        end
        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
